// File: rtl/rvvi_retire_tracer_if.sv
// ---------------------------------------------------------------------------
// rvvi_retire_tracer_if
//   Retirement-record handshake between a core's commit stage (master) and
//   the RVVI retire tracer (slave). One record moves when in_valid and
//   in_ready are both high at a rising clock edge.
//
//   in_valid     master -> slave   record valid
//   in_ready     slave  -> master  tracer can take a record this cycle
//   in_insn      master -> slave   instruction bits (ILEN)
//   in_pc        master -> slave   PC of the instruction (XLEN)
//   in_next_pc   master -> slave   next PC, handler PC when trapped (XLEN)
//   in_trap      master -> slave   instruction trapped
//   in_halt      master -> slave   instruction halted the hart
//   in_mode      master -> slave   privilege mode
//   in_rd_we     master -> slave   GPR write enable
//   in_rd        master -> slave   GPR index
//   in_rd_data   master -> slave   GPR write value (XLEN)
//   in_csr_we    master -> slave   CSR write enable
//   in_csr_addr  master -> slave   CSR address
//   in_csr_data  master -> slave   CSR write value (XLEN)
// ---------------------------------------------------------------------------
interface rvvi_retire_tracer_if #(
  parameter int ILEN = 32,
  parameter int XLEN = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [ILEN-1:0] in_insn;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_next_pc;
  logic            in_trap;
  logic            in_halt;
  logic [1:0]      in_mode;
  logic            in_rd_we;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_rd_data;
  logic            in_csr_we;
  logic [11:0]     in_csr_addr;
  logic [XLEN-1:0] in_csr_data;

  modport master (
    output in_valid, in_insn, in_pc, in_next_pc, in_trap, in_halt, in_mode,
           in_rd_we, in_rd, in_rd_data, in_csr_we, in_csr_addr, in_csr_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_insn, in_pc, in_next_pc, in_trap, in_halt, in_mode,
           in_rd_we, in_rd, in_rd_data, in_csr_we, in_csr_addr, in_csr_data,
    output in_ready
  );

endinterface

// File: rtl/rvvi_retire_tracer.sv
// ---------------------------------------------------------------------------
// rvvi_retire_tracer
//   Per-hart producer for the RVVI_VLG trace interface (ISSUE=1). Retirement
//   records arrive over in_if, are buffered in a DEPTH-entry FIFO and popped
//   one per cycle when out_en allows. Each pop produces a one-cycle valid
//   pulse with the registered RVVI fields, updates the shadow X register
//   file, and advances the 64-bit retire order count. A record with halt=1
//   parks the tracer in HALTED until a resume pulse.
//
//   clk, reset   clock; asynchronous active-high reset
//   in_if        retirement-record handshake (slave side)
//   out_en       downstream permits a pop this cycle
//   resume       pulse that leaves HALTED
//   valid        one-cycle retire pulse
//   order        retire order count, first retire is 1
//   insn, trap, halt, intr, mode, ixl, pc_rdata, pc_wdata
//                per-retire RVVI fields (hold between retires)
//   x_wdata      shadow X file, entry i at [i*XLEN +: XLEN]
//   x_wb         one-hot GPR written by this retire
//   csr_wb       a CSR was written by this retire
//   csr_addr, csr_wdata   last CSR write (hold between writes)
// ---------------------------------------------------------------------------
module rvvi_retire_tracer #(
  parameter int ILEN  = 32,
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  rvvi_retire_tracer_if.slave  in_if,
  input  logic                 out_en,
  input  logic                 resume,
  output logic                 valid,
  output logic [63:0]          order,
  output logic [ILEN-1:0]      insn,
  output logic                 trap,
  output logic                 halt,
  output logic                 intr,
  output logic [1:0]           mode,
  output logic [1:0]           ixl,
  output logic [XLEN-1:0]      pc_rdata,
  output logic [XLEN-1:0]      pc_wdata,
  output logic [32*XLEN-1:0]   x_wdata,
  output logic [31:0]          x_wb,
  output logic                 csr_wb,
  output logic [11:0]          csr_addr,
  output logic [XLEN-1:0]      csr_wdata
);

  localparam int         PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] IXL   = (XLEN == 64) ? 2'd2 : 2'd1;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } state_e;

  typedef struct packed {
    logic [ILEN-1:0] insn;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            trap;
    logic            halt;
    logic [1:0]      mode;
    logic            rd_we;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
    logic            csr_we;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_data;
  } rec_t;

  // -------------------------------------------------------------------------
  // FIFO storage and control
  // -------------------------------------------------------------------------
  rec_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  state_e           state_q,  state_d;
  logic             pend_intr_q, pend_intr_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  rec_t push_rec;
  rec_t head;

  // -------------------------------------------------------------------------
  // Registered RVVI outputs
  // -------------------------------------------------------------------------
  logic                      valid_q,     valid_d;
  logic [63:0]               order_q,     order_d;
  logic [ILEN-1:0]           insn_q,      insn_d;
  logic                      trap_q,      trap_d;
  logic                      halt_q,      halt_d;
  logic                      intr_q,      intr_d;
  logic [1:0]                mode_q,      mode_d;
  logic [1:0]                ixl_q,       ixl_d;
  logic [XLEN-1:0]           pc_rdata_q,  pc_rdata_d;
  logic [XLEN-1:0]           pc_wdata_q,  pc_wdata_d;
  logic [31:0][XLEN-1:0]     x_wdata_q,   x_wdata_d;
  logic [31:0]               x_wb_q,      x_wb_d;
  logic                      csr_wb_q,    csr_wb_d;
  logic [11:0]               csr_addr_q,  csr_addr_d;
  logic [XLEN-1:0]           csr_wdata_q, csr_wdata_d;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

  // Ready depends only on registered state, so a pop in the same cycle
  // never opens a slot for a push while full.
  assign in_if.in_ready = !full && (state_q == ST_RUN);

  assign push = in_if.in_valid && in_if.in_ready;
  assign pop  = (state_q == ST_RUN) && !empty && out_en;

  assign push_rec = '{
    insn:     in_if.in_insn,
    pc:       in_if.in_pc,
    next_pc:  in_if.in_next_pc,
    trap:     in_if.in_trap,
    halt:     in_if.in_halt,
    mode:     in_if.in_mode,
    rd_we:    in_if.in_rd_we,
    rd:       in_if.in_rd,
    rd_data:  in_if.in_rd_data,
    csr_we:   in_if.in_csr_we,
    csr_addr: in_if.in_csr_addr,
    csr_data: in_if.in_csr_data
  };

  assign head = mem_q[rd_ptr_q];

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned (which would infer a latch); combinational logic uses
    // blocking '=' so later statements see the updated value.
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pend_intr_d = pend_intr_q;

    valid_d     = 1'b0;
    x_wb_d      = '0;
    csr_wb_d    = 1'b0;
    order_d     = order_q;
    insn_d      = insn_q;
    trap_d      = trap_q;
    halt_d      = halt_q;
    intr_d      = intr_q;
    mode_d      = mode_q;
    ixl_d       = IXL;
    pc_rdata_d  = pc_rdata_q;
    pc_wdata_d  = pc_wdata_q;
    x_wdata_d   = x_wdata_q;
    csr_addr_d  = csr_addr_q;
    csr_wdata_d = csr_wdata_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      valid_d    = 1'b1;
      order_d    = order_q + 64'd1;
      insn_d     = head.insn;
      trap_d     = head.trap;
      halt_d     = head.halt;
      mode_d     = head.mode;
      pc_rdata_d = head.pc;
      pc_wdata_d = head.next_pc;

      // intr marks the first retire after a trapped one; a trapped retire
      // re-arms it for the next.
      intr_d      = pend_intr_q;
      pend_intr_d = head.trap;

      // A trapped instruction does not architecturally write rd.
      if (head.rd_we && !head.trap && (head.rd != 5'd0)) begin
        x_wdata_d[head.rd] = head.rd_data;
        x_wb_d             = 32'd1 << head.rd;
      end

      // CSR writes are reported even on trap (e.g. handler CSR updates).
      if (head.csr_we) begin
        csr_wb_d    = 1'b1;
        csr_addr_d  = head.csr_addr;
        csr_wdata_d = head.csr_data;
      end

      // The halting record still retires; resume in this cycle is ignored.
      if (head.halt) begin
        state_d = ST_HALTED;
      end
    end else if ((state_q == ST_HALTED) && resume) begin
      state_d = ST_RUN;
    end

    x_wdata_d[0] = '0;
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pend_intr_q <= 1'b0;
      valid_q     <= 1'b0;
      order_q     <= '0;
      insn_q      <= '0;
      trap_q      <= 1'b0;
      halt_q      <= 1'b0;
      intr_q      <= 1'b0;
      mode_q      <= '0;
      ixl_q       <= '0;
      pc_rdata_q  <= '0;
      pc_wdata_q  <= '0;
      x_wdata_q   <= '0;
      x_wb_q      <= '0;
      csr_wb_q    <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pend_intr_q <= pend_intr_d;
      valid_q     <= valid_d;
      order_q     <= order_d;
      insn_q      <= insn_d;
      trap_q      <= trap_d;
      halt_q      <= halt_d;
      intr_q      <= intr_d;
      mode_q      <= mode_d;
      ixl_q       <= ixl_d;
      pc_rdata_q  <= pc_rdata_d;
      pc_wdata_q  <= pc_wdata_d;
      x_wdata_q   <= x_wdata_d;
      x_wb_q      <= x_wb_d;
      csr_wb_q    <= csr_wb_d;
      csr_addr_q  <= csr_addr_d;
      csr_wdata_q <= csr_wdata_d;
    end
  end

  // NOTE: FIFO storage has no reset; an entry is only read after it has
  // been written, and reset empties the FIFO through its pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_rec;
    end
  end

  assign valid     = valid_q;
  assign order     = order_q;
  assign insn      = insn_q;
  assign trap      = trap_q;
  assign halt      = halt_q;
  assign intr      = intr_q;
  assign mode      = mode_q;
  assign ixl       = ixl_q;
  assign pc_rdata  = pc_rdata_q;
  assign pc_wdata  = pc_wdata_q;
  assign x_wdata   = x_wdata_q;
  assign x_wb      = x_wb_q;
  assign csr_wb    = csr_wb_q;
  assign csr_addr  = csr_addr_q;
  assign csr_wdata = csr_wdata_q;

endmodule

// File: tb/tb_rvvi_retire_tracer.sv
// ---------------------------------------------------------------------------
// tb_rvvi_retire_tracer
//   Self-checking bench for rvvi_retire_tracer. A queue-based reference model
//   (pending records, halted flag, shadow registers, order count) predicts
//   in_ready, which edges pop, and the RVVI fields of every retire.
// ---------------------------------------------------------------------------
module tb_rvvi_retire_tracer;

  localparam int         ILEN    = 32;
  localparam int         XLEN    = 32;
  localparam int         DEPTH   = 4;
  localparam logic [1:0] IXL_EXP = 2'd1;

  typedef struct {
    logic [ILEN-1:0] insn;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            trap;
    logic            halt;
    logic [1:0]      mode;
    logic            rd_we;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
    logic            csr_we;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_data;
  } rec_t;

  typedef struct {
    logic [63:0]        order;
    logic [ILEN-1:0]    insn;
    logic               trap;
    logic               halt;
    logic               intr;
    logic [1:0]         mode;
    logic [1:0]         ixl;
    logic [XLEN-1:0]    pc_r;
    logic [XLEN-1:0]    pc_w;
    logic [31:0]        x_wb;
    logic               csr_wb;
    logic [11:0]        csr_addr;
    logic [XLEN-1:0]    csr_wdata;
    logic [32*XLEN-1:0] xdat;
  } obs_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                out_en;
  logic                resume;
  logic                valid;
  logic [63:0]         order;
  logic [ILEN-1:0]     insn;
  logic                trap;
  logic                halt;
  logic                intr;
  logic [1:0]          mode;
  logic [1:0]          ixl;
  logic [XLEN-1:0]     pc_rdata;
  logic [XLEN-1:0]     pc_wdata;
  logic [32*XLEN-1:0]  x_wdata;
  logic [31:0]         x_wb;
  logic                csr_wb;
  logic [11:0]         csr_addr;
  logic [XLEN-1:0]     csr_wdata;

  rvvi_retire_tracer_if #(.ILEN(ILEN), .XLEN(XLEN)) bus ();

  rvvi_retire_tracer #(.ILEN(ILEN), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_if     (bus.slave),
    .out_en    (out_en),
    .resume    (resume),
    .valid     (valid),
    .order     (order),
    .insn      (insn),
    .trap      (trap),
    .halt      (halt),
    .intr      (intr),
    .mode      (mode),
    .ixl       (ixl),
    .pc_rdata  (pc_rdata),
    .pc_wdata  (pc_wdata),
    .x_wdata   (x_wdata),
    .x_wb      (x_wb),
    .csr_wb    (csr_wb),
    .csr_addr  (csr_addr),
    .csr_wdata (csr_wdata)
  );

  always #5 clk = ~clk;

  // Counters
  int checks = 0;
  int errors = 0;

  // Reference model state
  rec_t            mq[$];
  obs_t            exp_q[$];
  obs_t            cap[$];
  bit              m_halted;
  bit              m_last_trap;
  logic [63:0]     m_order;
  logic [XLEN-1:0] m_x [32];
  logic [11:0]     m_csr_addr;
  logic [XLEN-1:0] m_csr_data;
  logic [1:0]      m_ixl;
  rec_t            cur;
  bit              last_acc;
  int              ready_bad;
  int              valid_bad;

  function automatic rec_t idle_rec();
    rec_t r;
    r.insn = '0; r.pc = '0; r.next_pc = '0; r.trap = 1'b0; r.halt = 1'b0;
    r.mode = 2'd3; r.rd_we = 1'b0; r.rd = '0; r.rd_data = '0;
    r.csr_we = 1'b0; r.csr_addr = '0; r.csr_data = '0;
    return r;
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    r.insn     = $urandom();
    r.pc       = $urandom();
    r.next_pc  = $urandom();
    r.trap     = ($urandom_range(0, 9) < 2);
    r.halt     = ($urandom_range(0, 19) == 0);
    r.mode     = 2'($urandom_range(0, 3));
    r.rd_we    = ($urandom_range(0, 9) < 7);
    r.rd       = 5'($urandom_range(0, 31));
    r.rd_data  = $urandom();
    r.csr_we   = ($urandom_range(0, 9) < 3);
    r.csr_addr = 12'($urandom_range(0, 4095));
    r.csr_data = $urandom();
    return r;
  endfunction

  task automatic drive(input bit v, input rec_t r);
    cur              = r;
    bus.in_valid     = v;
    bus.in_insn      = r.insn;
    bus.in_pc        = r.pc;
    bus.in_next_pc   = r.next_pc;
    bus.in_trap      = r.trap;
    bus.in_halt      = r.halt;
    bus.in_mode      = r.mode;
    bus.in_rd_we     = r.rd_we;
    bus.in_rd        = r.rd;
    bus.in_rd_data   = r.rd_data;
    bus.in_csr_we    = r.csr_we;
    bus.in_csr_addr  = r.csr_addr;
    bus.in_csr_data  = r.csr_data;
  endtask

  // Advance one clock: the model decides push/pop from the pre-edge inputs,
  // then DUT outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    bit   pred_ready;
    bit   do_push;
    bit   do_pop;
    bit   was_halted;
    bit   resume_s;
    rec_t pushed;
    rec_t p;
    obs_t o;
    obs_t c;
    pred_ready = (mq.size() < DEPTH) && !m_halted;
    if (bus.in_ready !== pred_ready) ready_bad++;
    do_push    = bus.in_valid && pred_ready;
    do_pop     = !m_halted && (mq.size() != 0) && out_en;
    was_halted = m_halted;
    resume_s   = resume;
    pushed     = cur;
    @(posedge clk);
    if (do_pop) begin
      p = mq.pop_front();
      m_order     = m_order + 64'd1;
      o.order     = m_order;
      o.insn      = p.insn;
      o.trap      = p.trap;
      o.halt      = p.halt;
      o.intr      = m_last_trap;
      m_last_trap = p.trap;
      o.mode      = p.mode;
      o.ixl       = IXL_EXP;
      o.pc_r      = p.pc;
      o.pc_w      = p.next_pc;
      o.x_wb      = '0;
      if (p.rd_we && !p.trap && p.rd != 0) begin
        m_x[p.rd] = p.rd_data;
        o.x_wb    = 32'd1 << p.rd;
      end
      if (p.csr_we) begin
        m_csr_addr = p.csr_addr;
        m_csr_data = p.csr_data;
      end
      o.csr_wb    = p.csr_we;
      o.csr_addr  = m_csr_addr;
      o.csr_wdata = m_csr_data;
      for (int i = 0; i < 32; i++) o.xdat[i*XLEN +: XLEN] = m_x[i];
      exp_q.push_back(o);
    end
    if (was_halted) m_halted = !resume_s;
    else if (do_pop && p.halt) m_halted = 1'b1;
    if (do_push) mq.push_back(pushed);
    last_acc = do_push;
    m_ixl    = IXL_EXP;
    #1;
    if (valid !== do_pop) valid_bad++;
    if (!do_pop && (x_wb !== 32'd0 || csr_wb !== 1'b0)) valid_bad++;
    if (valid === 1'b1) begin
      c.order = order; c.insn = insn; c.trap = trap; c.halt = halt;
      c.intr = intr; c.mode = mode; c.ixl = ixl; c.pc_r = pc_rdata;
      c.pc_w = pc_wdata; c.x_wb = x_wb; c.csr_wb = csr_wb;
      c.csr_addr = csr_addr; c.csr_wdata = csr_wdata; c.xdat = x_wdata;
      cap.push_back(c);
    end
  endtask

  task automatic push_rec(input rec_t r);
    bit done;
    done = 1'b0;
    drive(1'b1, r);
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      done = last_acc;
    end
    drive(1'b0, idle_rec());
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL push_accept: insn %h not accepted within 20 cycles", r.insn);
    end
  endtask

  task automatic apply_reset();
    reset  = 1'b1;
    out_en = 1'b0;
    resume = 1'b0;
    drive(1'b0, idle_rec());
    mq.delete(); exp_q.delete(); cap.delete();
    m_halted = 1'b0; m_last_trap = 1'b0; m_order = '0; m_ixl = 2'd0;
    m_csr_addr = '0; m_csr_data = '0;
    for (int i = 0; i < 32; i++) m_x[i] = '0;
    ready_bad = 0; valid_bad = 0;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    #10;
    checks++;
    if ({valid, order, insn, trap, halt, intr, mode, ixl, pc_rdata, pc_wdata,
         x_wb, csr_wb, csr_addr, csr_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b order=%0d insn=%h ixl=%0d required all 0",
               valid, order, insn, ixl);
    end
    checks++;
    if (x_wdata !== '0) begin
      errors++;
      $display("FAIL reset_xfile: got nonzero x_wdata required 0");
    end
    release_reset();
    cycle();
    checks++;
    if (ixl !== m_ixl) begin
      errors++;
      $display("FAIL reset_ixl: got %0d required %0d", ixl, m_ixl);
    end
    checks++;
    if (valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: got valid=%b in_ready=%b required valid=0 in_ready=1",
               valid, bus.in_ready);
    end
  endtask

  task automatic test_addi();
    rec_t r;
    apply_reset();
    release_reset();
    out_en = 1'b1;
    r = idle_rec();
    r.insn = 32'h02A00293; r.pc = 32'h8000_0000; r.next_pc = 32'h8000_0004;
    r.rd_we = 1'b1; r.rd = 5'd5; r.rd_data = 32'h2A;
    drive(1'b1, r);
    cycle();
    drive(1'b0, idle_rec());
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL addi_latency_early: got valid=%b at accept edge required 0", valid);
    end
    cycle();
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL addi_latency: got valid=%b one edge after accept required 1", valid);
    end
    for (int i = 0; i < 3; i++) cycle();
    checks++;
    if (cap.size() != 1) begin
      errors++;
      $display("FAIL addi_count: got %0d valids required 1", cap.size());
    end else begin
      checks++;
      if (cap[0].order !== 64'd1 || cap[0].x_wb !== 32'h0000_0020 ||
          cap[0].xdat[5*XLEN +: XLEN] !== 32'h2A || cap[0].ixl !== 2'd1) begin
        errors++;
        $display("FAIL addi_fields: got order=%0d x_wb=%h x5=%h ixl=%0d required 1 00000020 2a 1",
                 cap[0].order, cap[0].x_wb, cap[0].xdat[5*XLEN +: XLEN], cap[0].ixl);
      end
    end
    checks++;
    if (x_wdata[5*XLEN +: XLEN] !== 32'h2A || x_wb !== 32'd0) begin
      errors++;
      $display("FAIL addi_hold: got x5=%h x_wb=%h required 2a 0",
               x_wdata[5*XLEN +: XLEN], x_wb);
    end
  endtask

  task automatic test_back_to_back();
    rec_t r;
    int   pushed;
    apply_reset();
    release_reset();
    pushed = 0;
    for (int c = 0; c < 6; c++) begin
      r = idle_rec();
      r.insn = 32'h100 + 32'(pushed);
      r.pc   = 32'h1000 + 32'(pushed * 4);
      drive(1'b1, r);
      cycle();
      if (last_acc) pushed++;
    end
    drive(1'b0, idle_rec());
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full_ready: got in_ready=%b with FIFO full required 0", bus.in_ready);
    end
    out_en = 1'b1;
    cycle();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_after_pop: got in_ready=%b required 1", bus.in_ready);
    end
    for (int i = 0; i < 6; i++) cycle();
    checks++;
    if (cap.size() != DEPTH) begin
      errors++;
      $display("FAIL b2b_count: got %0d valids required %0d", cap.size(), DEPTH);
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        checks++;
        if (cap[k].order !== 64'(k + 1) || cap[k].insn !== 32'h100 + 32'(k)) begin
          errors++;
          $display("FAIL b2b_order[%0d]: got order=%0d insn=%h required %0d %h",
                   k, cap[k].order, cap[k].insn, k + 1, 32'h100 + 32'(k));
        end
      end
    end
    checks++;
    if (ready_bad != 0 || valid_bad != 0) begin
      errors++;
      $display("FAIL b2b_timing: got %0d ready and %0d valid disagreements required 0",
               ready_bad, valid_bad);
    end
  endtask

  task automatic test_gpr_csr_intr();
    rec_t recs[7];
    bit   exp_intr[7];
    exp_intr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    apply_reset();
    release_reset();
    out_en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      recs[k] = idle_rec();
      recs[k].insn = 32'h300 + 32'(k);
    end
    recs[0].rd_we = 1'b1; recs[0].rd = 5'd0; recs[0].rd_data = 32'hFFFF;
    recs[1].trap = 1'b1; recs[1].rd_we = 1'b1; recs[1].rd = 5'd7; recs[1].rd_data = 32'h55;
    recs[1].csr_we = 1'b1; recs[1].csr_addr = 12'h342; recs[1].csr_data = 32'hB;
    recs[2].rd_we = 1'b1; recs[2].rd = 5'd3; recs[2].rd_data = 32'h33;
    recs[4].trap = 1'b1;
    recs[5].trap = 1'b1;
    for (int k = 0; k < 7; k++) push_rec(recs[k]);
    for (int i = 0; i < 6; i++) cycle();
    checks++;
    if (cap.size() != 7) begin
      errors++;
      $display("FAIL gpr_count: got %0d valids required 7", cap.size());
    end else begin
      checks++;
      if (cap[0].x_wb !== 32'd0 || cap[0].xdat[XLEN-1:0] !== '0) begin
        errors++;
        $display("FAIL gpr_x0: got x_wb=%h x0=%h required 0 0",
                 cap[0].x_wb, cap[0].xdat[XLEN-1:0]);
      end
      checks++;
      if (cap[1].trap !== 1'b1 || cap[1].x_wb !== 32'd0 || cap[1].xdat[7*XLEN +: XLEN] !== '0 ||
          cap[1].csr_wb !== 1'b1 || cap[1].csr_addr !== 12'h342 || cap[1].csr_wdata !== 32'hB) begin
        errors++;
        $display("FAIL gpr_trap_csr: got trap=%b x_wb=%h x7=%h csr_wb=%b addr=%h data=%h required 1 0 0 1 342 b",
                 cap[1].trap, cap[1].x_wb, cap[1].xdat[7*XLEN +: XLEN], cap[1].csr_wb,
                 cap[1].csr_addr, cap[1].csr_wdata);
      end
      checks++;
      if (cap[2].csr_wb !== 1'b0 || cap[2].csr_addr !== 12'h342 || cap[2].x_wb !== 32'h8) begin
        errors++;
        $display("FAIL gpr_after_trap: got csr_wb=%b addr=%h x_wb=%h required 0 342 00000008",
                 cap[2].csr_wb, cap[2].csr_addr, cap[2].x_wb);
      end
      for (int k = 0; k < 7; k++) begin
        checks++;
        if (cap[k].intr !== exp_intr[k]) begin
          errors++;
          $display("FAIL intr[%0d]: got %b required %b", k, cap[k].intr, exp_intr[k]);
        end
      end
    end
    checks++;
    if (x_wdata[XLEN-1:0] !== '0) begin
      errors++;
      $display("FAIL gpr_x0_final: got %h required 0", x_wdata[XLEN-1:0]);
    end
  endtask

  task automatic test_halt();
    rec_t r;
    apply_reset();
    release_reset();
    for (int k = 0; k < 3; k++) begin
      r = idle_rec();
      r.insn = 32'h400 + 32'(k);
      r.halt = (k == 0);
      push_rec(r);
    end
    out_en = 1'b1;
    resume = 1'b1;
    cycle();
    resume = 1'b0;
    checks++;
    if (valid !== 1'b1 || halt !== 1'b1 || order !== 64'd1) begin
      errors++;
      $display("FAIL halt_pop: got valid=%b halt=%b order=%0d required 1 1 1", valid, halt, order);
    end
    for (int i = 0; i < 4; i++) cycle();
    checks++;
    if (cap.size() != 1 || bus.in_ready !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_parked: got %0d valids in_ready=%b required 1 valid, in_ready=0",
               cap.size(), bus.in_ready);
    end
    resume = 1'b1;
    cycle();
    resume = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    checks++;
    if (cap.size() != 3) begin
      errors++;
      $display("FAIL halt_resume_count: got %0d valids required 3", cap.size());
    end else begin
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (cap[k].order !== 64'(k + 1) || cap[k].insn !== 32'h400 + 32'(k) || cap[k].halt !== 1'b0) begin
          errors++;
          $display("FAIL halt_resume[%0d]: got order=%0d insn=%h halt=%b required %0d %h 0",
                   k, cap[k].order, cap[k].insn, cap[k].halt, k + 1, 32'h400 + 32'(k));
        end
      end
    end
    checks++;
    if (bus.in_ready !== 1'b1 || ready_bad != 0 || valid_bad != 0) begin
      errors++;
      $display("FAIL halt_timing: got in_ready=%b ready_bad=%0d valid_bad=%0d required 1 0 0",
               bus.in_ready, ready_bad, valid_bad);
    end
  endtask

  task automatic test_reset_mid();
    rec_t r;
    apply_reset();
    release_reset();
    out_en = 1'b1;
    r = idle_rec();
    r.insn = 32'h500; r.rd_we = 1'b1; r.rd = 5'd9; r.rd_data = 32'h99;
    r.csr_we = 1'b1; r.csr_addr = 12'h300; r.csr_data = 32'h8;
    push_rec(r);
    for (int i = 0; i < 3; i++) cycle();
    out_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      r = idle_rec();
      r.insn = 32'h510 + 32'(k);
      push_rec(r);
    end
    apply_reset();
    checks++;
    if ({valid, order, insn, trap, halt, intr, mode, ixl, pc_rdata, pc_wdata,
         x_wb, csr_wb, csr_addr, csr_wdata} !== '0 || x_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got order=%0d insn=%h csr_addr=%h x9=%h required all 0",
               order, insn, csr_addr, x_wdata[9*XLEN +: XLEN]);
    end
    release_reset();
    out_en = 1'b1;
    r = idle_rec();
    r.insn = 32'h520;
    push_rec(r);
    for (int i = 0; i < 5; i++) cycle();
    checks++;
    if (cap.size() != 1 || cap[0].order !== 64'd1 || cap[0].insn !== 32'h520) begin
      errors++;
      $display("FAIL reset_mid_new: got %0d valids first order=%0d required 1 valid order 1",
               cap.size(), (cap.size() != 0) ? cap[0].order : 64'd0);
    end
  endtask

  task automatic test_random();
    int shown;
    apply_reset();
    release_reset();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 9) < 6), rand_rec());
      out_en = ($urandom_range(0, 9) < 7);
      resume = ($urandom_range(0, 9) == 0);
      cycle();
    end
    drive(1'b0, idle_rec());
    out_en = 1'b1;
    resume = 1'b1;
    for (int i = 0; i < 200 && mq.size() != 0; i++) cycle();
    resume = 1'b0;
    cycle();
    cycle();
    checks++;
    if (mq.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: got %0d records still pending required 0", mq.size());
    end
    checks++;
    if (cap.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d valids required %0d", cap.size(), exp_q.size());
    end
    shown = 0;
    for (int k = 0; k < cap.size() && k < exp_q.size(); k++) begin
      checks++;
      if ({cap[k].order, cap[k].insn, cap[k].trap, cap[k].halt, cap[k].intr, cap[k].mode,
           cap[k].ixl, cap[k].pc_r, cap[k].pc_w, cap[k].x_wb, cap[k].csr_wb,
           cap[k].csr_addr, cap[k].csr_wdata} !==
          {exp_q[k].order, exp_q[k].insn, exp_q[k].trap, exp_q[k].halt, exp_q[k].intr,
           exp_q[k].mode, exp_q[k].ixl, exp_q[k].pc_r, exp_q[k].pc_w, exp_q[k].x_wb,
           exp_q[k].csr_wb, exp_q[k].csr_addr, exp_q[k].csr_wdata} ||
          cap[k].xdat !== exp_q[k].xdat) begin
        errors++;
        if (shown < 8) begin
          shown++;
          $display("FAIL rand_retire[%0d]: got order=%0d insn=%h intr=%b x_wb=%h csr=%b/%h required order=%0d insn=%h intr=%b x_wb=%h csr=%b/%h",
                   k, cap[k].order, cap[k].insn, cap[k].intr, cap[k].x_wb, cap[k].csr_wb,
                   cap[k].csr_addr, exp_q[k].order, exp_q[k].insn, exp_q[k].intr,
                   exp_q[k].x_wb, exp_q[k].csr_wb, exp_q[k].csr_addr);
        end
      end
    end
    checks++;
    if (ready_bad != 0 || valid_bad != 0) begin
      errors++;
      $display("FAIL rand_timing: got %0d ready and %0d valid disagreements required 0",
               ready_bad, valid_bad);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_gpr_csr_intr();
    test_halt();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
